// File: rtl/cycle_sequencer.sv
// -----------------------------------------------------------------------------
// cycle_sequencer
//
// Generates a two-phase, non-overlapping enable pattern (CLK1/CLK2) grouped
// into T0..T7 timing states. Each timing state is four sub-phases long. A
// memory WAIT can stretch T3 by whole sub-phase passes. A small control FSM
// selects between free-running, single-stepping one instruction cycle, and
// halted.
//
// Ports
//   CLK     in   system clock, rising edge active
//   RST     in   asynchronous reset, active low
//   RUN     in   free-run enable (level)
//   STEP    in   single-step request (rising edge)
//   WAIT    in   memory wait, sampled only at the end of T3
//   CLK1    out  phase-1 enable (sub-phase 0)
//   CLK2    out  phase-2 enable (sub-phase 2)
//   SYNC    out  high throughout T7
//   TSTATE  out  current timing state 0..7
//   HALTED  out  high while the sequencer is stopped
//
// Every output comes straight from a flop. These flops are loaded from the
// sub-phase and timing-state counters of the previous cycle. As a result, the
// visible pattern starts one cycle after the control FSM leaves HALT. That
// first cycle shows all enables low with HALTED already low.
// -----------------------------------------------------------------------------
module cycle_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RUN,
  input  logic       STEP,
  input  logic       WAIT,
  output logic       CLK1,
  output logic       CLK2,
  output logic       SYNC,
  output logic [2:0] TSTATE,
  output logic       HALTED
);

  // state       | meaning
  // ------------+-------------------------------------------------------------
  // ST_HALT     | stopped; counters frozen at 0, enables low, HALTED high
  // ST_RUNNING  | free-running; leaves only at the end of T7 with RUN low
  // ST_STEPPING | one full T0..T7 cycle; then RUNNING if RUN is high, else HALT
  typedef enum logic [1:0] {
    ST_HALT     = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] sub_q, sub_d;
  logic [2:0] tstate_q, tstate_d;
  logic       step_prev_q, step_prev_d;
  logic       clk1_q, clk1_d;
  logic       clk2_q, clk2_d;
  logic       sync_q, sync_d;
  logic [2:0] tout_q, tout_d;
  logic       halted_q, halted_d;

  logic step_rise;
  logic active;
  logic last_sub;
  logic cycle_end;
  logic hold_t3;
  logic stay_active;

  // A STEP that is high at the first edge after reset counts as a rising
  // edge, because the history register clears to 0 on reset.
  assign step_rise = STEP & ~step_prev_q;
  assign active    = (state_q != ST_HALT);
  assign last_sub  = active && (sub_q == 2'd3);
  assign cycle_end = last_sub && (tstate_q == 3'd7);
  // WAIT matters only on the edge that leaves the last sub-phase of T3.
  assign hold_t3   = last_sub && (tstate_q == 3'd3) && WAIT;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_HALT;
      sub_q       <= 2'd0;
      tstate_q    <= 3'd0;
      step_prev_q <= 1'b0;
      clk1_q      <= 1'b0;
      clk2_q      <= 1'b0;
      sync_q      <= 1'b0;
      tout_q      <= 3'd0;
      halted_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      tstate_q    <= tstate_d;
      step_prev_q <= step_prev_d;
      clk1_q      <= clk1_d;
      clk2_q      <= clk2_d;
      sync_q      <= sync_d;
      tout_q      <= tout_d;
      halted_q    <= halted_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_HALT: begin
        // RUN takes priority over a simultaneous STEP edge.
        if (RUN) begin
          state_d = ST_RUNNING;
        end else if (step_rise) begin
          state_d = ST_STEPPING;
        end
      end
      ST_RUNNING: begin
        if (cycle_end && !RUN) begin
          state_d = ST_HALT;
        end
      end
      ST_STEPPING: begin
        if (cycle_end) begin
          state_d = RUN ? ST_RUNNING : ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Counters and registered outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // The counters stay live only while the FSM is active now and stays
    // active. Entering HALT drops them straight back to 0. Leaving HALT
    // keeps them at 0 for one edge, which gives the idle first cycle.
    stay_active = active && (state_d != ST_HALT);

    sub_d    = 2'd0;
    tstate_d = 3'd0;
    if (stay_active) begin
      sub_d    = sub_q + 2'd1;
      tstate_d = tstate_q;
      if (last_sub && !hold_t3) begin
        tstate_d = tstate_q + 3'd1;
      end
    end

    clk1_d      = stay_active && (sub_q == 2'd0);
    clk2_d      = stay_active && (sub_q == 2'd2);
    sync_d      = stay_active && (tstate_q == 3'd7);
    tout_d      = stay_active ? tstate_q : 3'd0;
    halted_d    = (state_d == ST_HALT);
    step_prev_d = STEP;
  end

  assign CLK1   = clk1_q;
  assign CLK2   = clk2_q;
  assign SYNC   = sync_q;
  assign TSTATE = tout_q;
  assign HALTED = halted_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
module tb_cycle_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic       step;
  logic       wait_in;
  logic       clk1;
  logic       clk2;
  logic       sync;
  logic [2:0] tstate;
  logic       halted;

  cycle_sequencer dut (
    .CLK    (clk),
    .RST    (rst),
    .RUN    (run),
    .STEP   (step),
    .WAIT   (wait_in),
    .CLK1   (clk1),
    .CLK2   (clk2),
    .SYNC   (sync),
    .TSTATE (tstate),
    .HALTED (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Each entry holds the inputs for one clock edge and the outputs expected
  // in the cycle that follows that edge.
  typedef struct {
    logic       run;
    logic       step;
    logic       wt;
    logic       clk1;
    logic       clk2;
    logic       sync;
    logic [2:0] tstate;
    logic       halted;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic push(input logic r, input logic s, input logic w,
                      input logic c1, input logic c2, input logic sy,
                      input logic [2:0] t, input logic h, input string tag);
    exp_t e;
    e.run = r; e.step = s; e.wt = w;
    e.clk1 = c1; e.clk2 = c2; e.sync = sy; e.tstate = t; e.halted = h;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input string tag);
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, tag);
  endtask

  // This is the edge that leaves HALT. HALTED drops, but the enables stay
  // low for this one cycle.
  task automatic push_start(input logic r, input logic s, input string tag);
    push(r, s, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, tag);
  endtask

  // Pushes one instruction cycle.
  //   waits   - number of extra T3 passes.
  //   drop_t  - RUN stays high for T states below it; 8 keeps RUN high to the end.
  //   step_at - entry index that carries a STEP pulse; -1 for none.
  //   limit   - number of entries to push; -1 pushes the whole cycle.
  // WAIT is driven high everywhere in T1, T5 and T3 except the single edge
  // where the final T3 sample must read low.
  task automatic push_cycle(input int waits, input int drop_t, input int step_at,
                            input int limit, input string tag);
    int   k;
    int   n;
    logic r;
    logic w;
    logic s;
    k = 0;
    for (int t = 0; t < 8; t++) begin
      n = (t == 3) ? 4 * (waits + 1) : 4;
      for (int i = 0; i < n; i++) begin
        if (limit >= 0 && k >= limit) return;
        r = (t < drop_t);
        w = (t == 3) ? (i != n - 1) : (t == 1 || t == 5);
        s = (k == step_at);
        if (t == 7 && i == 3 && !r)
          push(r, s, w, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, tag);
        else
          push(r, s, w, (i % 4) == 0, (i % 4) == 2, t == 7, 3'(t), 1'b0, tag);
        k++;
      end
    end
  endtask

  task automatic run_queue();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      run     = e.run;
      step    = e.step;
      wait_in = e.wt;
      @(posedge clk);
      @(negedge clk);
      chk({e.tag, ".clk1"},    {2'b00, clk1},   {2'b00, e.clk1});
      chk({e.tag, ".clk2"},    {2'b00, clk2},   {2'b00, e.clk2});
      chk({e.tag, ".sync"},    {2'b00, sync},   {2'b00, e.sync});
      chk({e.tag, ".tstate"},  tstate,          e.tstate);
      chk({e.tag, ".halted"},  {2'b00, halted}, {2'b00, e.halted});
      chk({e.tag, ".overlap"}, {2'b00, clk1 & clk2}, 3'd0);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".clk1"},   {2'b00, clk1},   3'd0);
    chk({tag, ".clk2"},   {2'b00, clk2},   3'd0);
    chk({tag, ".sync"},   {2'b00, sync},   3'd0);
    chk({tag, ".tstate"}, tstate,          3'd0);
    chk({tag, ".halted"}, {2'b00, halted}, 3'd1);
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; step = 1'b0; wait_in = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("por");

    // Free run: a plain cycle, a cycle with two T3 waits, a plain cycle, then
    // a cycle where RUN drops in T2 and the sequencer halts.
    rst = 1'b1;
    push_start(1'b1, 1'b0, "start_run");
    push_cycle(0, 8, -1, -1, "run_c0");
    push_cycle(2, 8, -1, -1, "run_wait2");
    push_cycle(0, 8, -1, -1, "run_c2");
    push_cycle(0, 2, -1, -1, "run_drop_t2");
    repeat (3) push_idle("idle_after_drop");

    // Single step with one WAIT extension. A second STEP pulse arrives
    // mid-step and must not add a cycle.
    push_start(1'b0, 1'b1, "step_start");
    push_cycle(1, 0, 9, -1, "step_c");
    repeat (4) push_idle("after_step");

    // RUN and a STEP edge together: RUN wins and the sequencer keeps running.
    push_start(1'b1, 1'b1, "run_and_step");
    push_cycle(0, 8, -1, -1, "ras_c0");
    push_cycle(0, 8, -1, -1, "ras_c1");
    push_cycle(0, 8, -1, 23, "pre_reset");
    run_queue();

    // Assert reset in the middle of T5 sub-phase 2, while CLK2 is high.
    rst = 1'b0;
    #1;
    chk("reset_async.clk2", {2'b00, clk2}, 3'd0);
    check_reset("reset_mid");
    #2;
    rst = 1'b1;
    push_start(1'b1, 1'b0, "restart");
    push_cycle(0, 8, -1, -1, "restart_c0");
    push_cycle(0, 0, -1, -1, "final_halt");
    repeat (2) push_idle("idle_final");
    run_queue();

    // Hold STEP high through reset; it must still be seen as a rising edge.
    rst  = 1'b0;
    run  = 1'b0;
    step = 1'b1;
    #1;
    check_reset("reset_step_held");
    #2;
    rst = 1'b1;
    push_start(1'b0, 1'b1, "step_thru_reset");
    push_cycle(0, 0, -1, -1, "step_thru_c");
    repeat (2) push_idle("idle_end");
    run_queue();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
